// File: rtl/image_conv_engine_if.sv
// ---------------------------------------------------------------------------
// image_conv_engine_if
// Handshake, pixel and configuration bundle for image_conv_engine.
//   in_valid/in_ready/in_sof/in_pixel : raster-order pixel input stream
//   out_valid/out_ready/out_pixel/out_last : filtered pixel output stream
//   cfg_we/cfg_addr/cfg_wdata : kernel (addr 0..8) and shift (addr 9) writes
// Modports: slave = engine side, master = source/sink/config side.
// ---------------------------------------------------------------------------
interface image_conv_engine_if #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sof;
    logic [PIX_W-1:0]  in_pixel;
    logic              out_valid;
    logic              out_ready;
    logic [PIX_W-1:0]  out_pixel;
    logic              out_last;
    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic [COEF_W-1:0] cfg_wdata;

    modport slave (
        input  in_valid, in_sof, in_pixel, out_ready, cfg_we, cfg_addr, cfg_wdata,
        output in_ready, out_valid, out_pixel, out_last
    );

    modport master (
        output in_valid, in_sof, in_pixel, out_ready, cfg_we, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, out_pixel, out_last
    );
endinterface

// File: rtl/image_conv_engine.sv
// ---------------------------------------------------------------------------
// image_conv_engine
// Streaming 3x3 convolution over a raster image of IMG_W x IMG_H pixels.
// Two line buffers plus a 3x3 window feed nine signed products (stage 1),
// which are summed, arithmetic-shifted and limited into the output register
// (stage 2). One output per input pixel at row>=2, col>=2.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   conv_if : image_conv_engine_if.slave (pixel in, pixel out, config)
// Build option:
//   IMAGE_CONV_SATURATE_EN defined   -> result clamped to [0, 2^PIX_W-1]
//   IMAGE_CONV_SATURATE_EN undefined -> result wraps to its low PIX_W bits
// ---------------------------------------------------------------------------
module image_conv_engine #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input logic                clk,
    input logic                rst,
    image_conv_engine_if.slave conv_if
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = PIX_W + COEF_W + 1;   // one signed product
    localparam int SW = PIX_W + COEF_W + 5;   // full-precision 9-tap sum

    localparam logic [CW-1:0]        COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0]        ROW_MAX = RW'(IMG_H - 1);
    localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << PIX_W) - 1);

    // Position and configuration state
    logic [CW-1:0]              col_q, col_d, cur_col;
    logic [RW-1:0]              row_q, row_d, cur_row;
    logic signed [COEF_W-1:0]   k_q [9];
    logic [4:0]                 sh_q;

    // Line buffers: lb0 holds the previous row, lb1 the row before that
    logic [PIX_W-1:0]           lb0_q [IMG_W];
    logic [PIX_W-1:0]           lb1_q [IMG_W];

    // Window, index row*3+col; row 0 is the oldest row, col 0 the oldest column
    logic [PIX_W-1:0]           win_q [9];
    logic [PIX_W-1:0]           win_d [9];

    // Stage 1: products
    logic signed [PW-1:0]       prod_q [9];
    logic signed [PW-1:0]       prod_d [9];
    logic                       p_valid_q;
    logic                       p_last_q;
    logic [4:0]                 p_sh_q;

    // Stage 2: output register
    logic                       out_valid_q;
    logic                       out_last_q;
    logic [PIX_W-1:0]           out_pixel_q;

    logic                       advance;
    logic                       accept;
    logic                       qualify;
    logic                       last_px;
    logic signed [SW-1:0]       sum;
    logic signed [SW-1:0]       shifted;
    logic [PIX_W-1:0]           result;

    assign advance = !out_valid_q || conv_if.out_ready;
    assign accept  = conv_if.in_valid && advance;

    assign conv_if.in_ready  = advance;
    assign conv_if.out_valid = out_valid_q;
    assign conv_if.out_last  = out_last_q;
    assign conv_if.out_pixel = out_pixel_q;

    // in_sof relocates the current pixel to (0,0) regardless of the counters
    assign cur_col = conv_if.in_sof ? '0 : col_q;
    assign cur_row = conv_if.in_sof ? '0 : row_q;
    assign qualify = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    assign last_px = (cur_row == ROW_MAX) && (cur_col == COL_MAX);

    always_comb begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
        if (cur_col == COL_MAX) begin
            col_d = '0;
            row_d = (cur_row == ROW_MAX) ? '0 : cur_row + RW'(1);
        end
    end

    // Next window and its products: products are taken from the window as it
    // will stand after this pixel, so they use the coefficients of this cycle.
    always_comb begin
        for (int unsigned r = 0; r < 3; r++) begin
            win_d[r*3 + 0] = win_q[r*3 + 1];
            win_d[r*3 + 1] = win_q[r*3 + 2];
        end
        win_d[2] = lb1_q[cur_col];
        win_d[5] = lb0_q[cur_col];
        win_d[8] = conv_if.in_pixel;
        for (int unsigned i = 0; i < 9; i++) begin
            prod_d[i] = PW'($signed({1'b0, win_d[i]})) * PW'(k_q[i]);
        end
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            sum = sum + SW'(prod_q[i]);
        end
        shifted = sum >>> p_sh_q;
`ifdef IMAGE_CONV_SATURATE_EN
        if (shifted[SW-1]) begin
            result = '0;
        end else if (shifted > PIX_MAX) begin
            result = '1;
        end else begin
            result = PIX_W'(shifted);
        end
`else
        result = PIX_W'(shifted);
`endif
    end

    // Data-only storage: never reset, stale contents are masked by qualify
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[cur_col] <= lb0_q[cur_col];
            lb0_q[cur_col] <= conv_if.in_pixel;
            for (int unsigned i = 0; i < 9; i++) begin
                win_q[i]  <= win_d[i];
                prod_q[i] <= prod_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            for (int unsigned i = 0; i < 9; i++) begin
                k_q[i] <= (i == 4) ? COEF_W'(1) : '0;
            end
            sh_q        <= '0;
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            p_sh_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pixel_q <= '0;
        end else begin
            if (conv_if.cfg_we) begin
                if (conv_if.cfg_addr < 4'd9) begin
                    k_q[conv_if.cfg_addr] <= conv_if.cfg_wdata;
                end else if (conv_if.cfg_addr == 4'd9) begin
                    sh_q <= conv_if.cfg_wdata[4:0];
                end
            end
            if (accept) begin
                col_q  <= col_d;
                row_q  <= row_d;
                p_sh_q <= sh_q;
            end
            // Both stages move together; a stalled output freezes everything.
            if (advance) begin
                p_valid_q   <= accept && qualify;
                p_last_q    <= accept && last_px;
                out_valid_q <= p_valid_q;
                out_last_q  <= p_valid_q && p_last_q;
                if (p_valid_q) begin
                    out_pixel_q <= result;
                end
            end
        end
    end
endmodule

// File: doc/image_conv_engine.md
IMAGE_CONV_ENGINE -- requirements
Module: image_conv_engine

Interface
REQ-001 Parameter PIX_W, default 8, pixel width in bits (unsigned).
REQ-002 Parameter COEF_W, default 8, kernel coefficient width (two's complement).
REQ-003 Parameter IMG_W, default 640, pixels per row, range 3..4096.
REQ-004 Parameter IMG_H, default 480, rows per frame, range 3..4096.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  in_pixel is valid this cycle.
REQ-008 in_ready  out  1  engine accepts in_pixel this cycle.
REQ-009 in_sof  in  1  accepted pixel is row 0, column 0 of a new frame.
REQ-010 in_pixel  in  PIX_W  raster-order input pixel.
REQ-011 out_valid  out  1  out_pixel is valid.
REQ-012 out_ready  in  1  downstream accepts out_pixel.
REQ-013 out_pixel  out  PIX_W  filtered pixel.
REQ-014 out_last  out  1  out_pixel is the final output of the frame.
REQ-015 cfg_we  in  1  configuration write strobe.
REQ-016 cfg_addr  in  4  0..8 = kernel coefficient k[row*3+col], 9 = right-shift amount; 10..15 ignored.
REQ-017 cfg_wdata  in  COEF_W  write data; for address 9 only bits [4:0] are used.

Function
REQ-018 Transfer occurs on a valid&&ready cycle at either port; advance = !out_valid || out_ready; in_ready SHALL equal advance.
REQ-019 Two line buffers of IMG_W x PIX_W and a 3x3 window register SHALL shift on every accepted pixel.
REQ-020 Column counter SHALL wrap IMG_W-1 -> 0 and increment the row counter; row counter SHALL wrap IMG_H-1 -> 0.
REQ-021 in_sof on an accepted pixel SHALL force that pixel to row 0, column 0, including mid-frame (partial frame discarded, no out_last emitted for it).
REQ-022 An output SHALL be produced only for accepted pixels with row>=2 and column>=2, giving (IMG_W-2)*(IMG_H-2) outputs per frame, centred on (row-1, col-1).
REQ-023 Result = sum over 9 taps of k[i]*pixel[i], full precision (PIX_W+COEF_W+5 bits signed), arithmetic right-shifted by the shift amount.
REQ-024 Pipeline SHALL be two stages (products registered, then sum/shift/limit into the output register); with out_ready held high, out_valid rises exactly 2 cycles after the qualifying pixel is accepted.
REQ-025 While out_valid && !out_ready, all stages, line buffers and counters SHALL hold; no output lost or duplicated.
REQ-026 out_last SHALL be 1 with the output for input row IMG_H-1, column IMG_W-1.
REQ-027 Configuration writes take effect for pixels accepted on a later cycle; a write and an accept in the same cycle use the old value.

Reset
REQ-028 On rst: out_valid=0, out_pixel=0, out_last=0, stage valids=0, row=column=0.
REQ-029 On rst: k[4]=1, all other coefficients 0, shift=0 (identity kernel).
REQ-030 Line buffer contents are not reset; the first two rows after reset or sof never produce outputs, so stale data is never emitted.
REQ-031 rst asserted mid-frame SHALL discard all in-flight results; the next accepted pixel is row 0, column 0.

Configuration
REQ-032 Macro IMAGE_CONV_SATURATE_EN defined: result SHALL saturate to 0 if negative and to 2^PIX_W-1 if above it.
REQ-033 Macro IMAGE_CONV_SATURATE_EN undefined: result SHALL be truncated to its low PIX_W bits (modulo wrap).

Verification (IMG_W=4, IMG_H=4, PIX_W=8)
REQ-034 Reset, identity kernel, frame pixels 0..15, out_ready=1 -> outputs 5,6,9,10 in order; out_last only with 10; each 2 cycles after pixels 10,11,14,15.
REQ-035 Box kernel (all k=1, shift=3), constant 16-pixel frame of 8 -> four outputs of 9 (72>>3).
REQ-036 Laplacian (k[4]=8, others -1), centre 255, neighbours 0 -> 255 with saturation macro; 0xF8 (2040 mod 256) without.
REQ-037 out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, out_pixel stable, sequence of REQ-034 unchanged after release.
REQ-038 in_sof asserted at pixel 6 of a frame, then full 16-pixel frame -> exactly 4 outputs, values per REQ-034 relative to the new frame.
REQ-039 rst pulsed after pixel 11 accepted -> out_valid=0 asynchronously; next frame yields 4 correct outputs with identity kernel.
